fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised forwarding and hazard unit for the pipelined core, sitting beside the ID stage. It tracks the destination register of every in-flight instruction in a shift register of `DEPTH` stages. From that it produces per-operand bypass selects for the EX stage (registered) and for ID-stage branch/jump compares (combinational). It also raises the load-use / multi-cycle stall and counts stall cycles. It generalises fixed two-operand MEM/WB forwarding to N source operands, configurable result latency per instruction, and arbitrary pipeline depth.

## Interface
- `NUM_SRC`, 2, source operands per instruction
- `AW`, 5, register address width; address 0 is hardwired zero
- `DEPTH`, 3, tracked stages after ID (slot 0 = EX, 1 = MEM, 2 = WB, …)
- `LW`, 2, latency field width; latency range 1..DEPTH
- `SW` (localparam), $clog2(DEPTH+1), select width
- `CW`, 32, stall counter width

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  valid instruction in ID
- `id_src`  in  NUM_SRC*AW  source register addresses, operand i at [i*AW +: AW]
- `id_src_use`  in  NUM_SRC  operand i is read
- `id_src_early`  in  NUM_SRC  operand i is consumed in ID (branch compare, jr)
- `id_we`, `id_dst`, `id_lat`  in  1, AW, LW  register write, destination, slots until result exists
- `ex_flush`  in  1  squash the instruction in EX and in ID
- `stall`  out  1  hold PC and IF/ID; bubble into EX
- `id_fwd_sel`  out  NUM_SRC*SW  combinational ID bypass select; 0 = register file, k = output of slot k
- `ex_fwd_sel`  out  NUM_SRC*SW  registered EX bypass select; same encoding
- `stall_cnt`  out  CW  saturating count of stall cycles

## Operation
- Slot entry: {valid, we, dst, lat}. Each edge, slots shift s -> s+1; slot DEPTH-1 retires to the register file.
- Insert at slot 0: the ID instruction when `id_valid && !stall && !ex_flush`, otherwise a bubble (valid = 0).
- Match for operand i: `id_src_use[i]`, `id_src[i] != 0`, and an entry with valid, we, dst == src. Use only the youngest match (lowest s).
- EX path (operand i, youngest match in slot s):
  - s+1 >= lat and s+1 < DEPTH: next `ex_fwd_sel` = s+1.
  - s+1 == DEPTH: select 0. The register file must be write-before-read.
  - s+1 < lat: hazard.
- ID path (only when `id_src_early[i]`): s >= lat and s >= 1 gives `id_fwd_sel` = s. Otherwise hazard. No match gives 0.
- `stall` = `id_valid && !ex_flush && any hazard`.
- `ex_fwd_sel` loads the computed selects on an insert and loads 0 on a bubble.
- `stall_cnt` increments on each `stall` cycle and saturates at all-ones.
- `ex_flush` clears slot 0 at the edge (it shifts into slot 1 as a bubble), blocks insertion, and suppresses `stall` that cycle.
- `id_lat` of 0 is treated as 1. `id_lat` > DEPTH is clamped to DEPTH.

## Timing
- Reset (async, `reset` low): all slots invalid, `ex_fwd_sel` = 0, `stall_cnt` = 0. `stall` and `id_fwd_sel` then evaluate to 0.
- `stall`, `id_fwd_sel`: combinational from inputs and slot state, same cycle.
- `ex_fwd_sel`: valid in the cycle the instruction occupies EX (one edge after leaving ID).
- A load (lat 2) followed by a dependent instruction gives exactly 1 stall cycle; then `ex_fwd_sel` = 2.
- A lat-L producer with its consumer directly behind it stalls L-1 cycles for the EX path.
- Reset asserted mid-stall drops `stall` immediately; no entry survives.

## Structure
- Shared package `fwd_pkg`:
  - select encodings `FWD_RF` = 0, `FWD_MEM` = 1, `FWD_WB` = 2
  - slot entry struct type
  - latency constants `LAT_ALU` = 1, `LAT_LOAD` = 2
- One sub-module, `fwd_match`: for one operand, searches the slots and returns {hit, slot, ready_ex, ready_id}. It is instantiated NUM_SRC times.

## Test plan
- ALU producer `$8` (lat 1), then consumer reading `$8` -> no stall; `ex_fwd_sel[0]` = 1 next cycle. With one independent instruction between them -> sel = 2. With two between -> sel = 0.
- Load into `$9`, then consumer reading `$9` on operand 1 -> `stall` high exactly 1 cycle, `stall_cnt` = 1, then `ex_fwd_sel[1]` = 2.
- Producer writing `$0` with `id_we` = 1, consumer reading `$0` -> no stall, sel = 0.
- Two in-flight writers of `$5` (slots 0 and 1, both ready), consumer reads `$5` -> select follows the younger: `ex_fwd_sel` = 1.
- Branch with `id_src_early` reading `$3`, ALU writer of `$3` directly ahead -> 1 stall cycle, then `id_fwd_sel` = 1. With DEPTH = 4 and a lat-3 multiply -> the EX-path consumer stalls 2 cycles, then sel = 3.
- Load hazard with `ex_flush` asserted in the same cycle -> `stall` = 0, bubble in EX, `stall_cnt` unchanged. Reset pulsed mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard scoreboard.
// Slot fields use fixed maximum widths so one struct type serves every parameterisation.
package fwd_pkg;

  localparam int FWD_RF  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Upper bounds on register address width and latency width held in a slot.
  localparam int SLOT_AW = 8;
  localparam int SLOT_LW = 8;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [SLOT_AW-1:0] dst;
    logic [SLOT_LW-1:0] lat;
  } slot_t;

  // A latency of 0 means 1; anything beyond the tracked depth saturates to it.
  function automatic int norm_lat(input int lat, input int depth);
    if (lat < 1) return 1;
    if (lat > depth) return depth;
    return lat;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand search of the in-flight slots: youngest matching writer and
// whether its result is available to the EX stage and to an ID-stage compare.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SW    = 2
) (
  input  logic [AW-1:0] src,
  input  logic          src_use,
  input  slot_t         slots [DEPTH],
  output logic          hit,
  output logic [SW-1:0] slot,
  output logic          ready_ex,
  output logic          ready_id
);

  always_comb begin
    hit      = 1'b0;
    slot     = '0;
    ready_ex = 1'b0;
    ready_id = 1'b0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (src_use && (src != '0) && slots[s].valid && slots[s].we &&
          (slots[s].dst == SLOT_AW'(src))) begin
        hit      = 1'b1;
        slot     = SW'(s);
        ready_ex = (s + 1) >= int'(slots[s].lat);
        ready_id = (s >= 1) && (s >= int'(slots[s].lat));
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit beside ID: tracks in-flight destinations, produces
// EX (registered) and ID (combinational) bypass selects, stall and a stall counter.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int AW      = 5,
  parameter  int DEPTH   = 3,
  parameter  int LW      = 2,
  parameter  int CW      = 32,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_use,
  input  logic [NUM_SRC-1:0]    id_src_early,
  input  logic                  id_we,
  input  logic [AW-1:0]         id_dst,
  input  logic [LW-1:0]         id_lat,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic [NUM_SRC*SW-1:0] id_fwd_sel,
  output logic [NUM_SRC*SW-1:0] ex_fwd_sel,
  output logic [CW-1:0]         stall_cnt
);

  slot_t               slots [DEPTH];
  slot_t               new_entry;
  logic [NUM_SRC-1:0]  hit;
  logic [NUM_SRC-1:0]  rdy_ex;
  logic [NUM_SRC-1:0]  rdy_id;
  logic [SW-1:0]       hit_slot [NUM_SRC];
  logic [NUM_SRC*SW-1:0] ex_sel_next;
  logic                hazard;
  logic                insert;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
    fwd_match #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_match (
      .src      (id_src[g*AW +: AW]),
      .src_use  (id_src_use[g]),
      .slots    (slots),
      .hit      (hit[g]),
      .slot     (hit_slot[g]),
      .ready_ex (rdy_ex[g]),
      .ready_id (rdy_id[g])
    );
  end

  always_comb begin
    hazard      = 1'b0;
    ex_sel_next = '0;
    id_fwd_sel  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_sel_next[i*SW +: SW] = SW'(FWD_RF);
      id_fwd_sel[i*SW +: SW]  = SW'(FWD_RF);
      if (hit[i]) begin
        // A producer in the last slot is written back this edge; the register file covers it.
        if (!rdy_ex[i]) begin
          hazard = 1'b1;
        end else if (int'(hit_slot[i]) + 1 < DEPTH) begin
          ex_sel_next[i*SW +: SW] = hit_slot[i] + 1'b1;
        end
        if (id_src_early[i]) begin
          if (rdy_id[i]) id_fwd_sel[i*SW +: SW] = hit_slot[i];
          else           hazard = 1'b1;
        end
      end
    end
  end

  assign stall  = id_valid && !ex_flush && hazard;
  assign insert = id_valid && !stall && !ex_flush;

  always_comb begin
    new_entry       = '0;
    new_entry.valid = 1'b1;
    new_entry.we    = id_we;
    new_entry.dst   = SLOT_AW'(id_dst);
    new_entry.lat   = SLOT_LW'(norm_lat(int'(id_lat), DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) slots[s] <= '0;
      ex_fwd_sel <= '0;
      stall_cnt  <= '0;
    end else begin
      slots[0] <= insert ? new_entry : '0;
      // A flushed EX instruction moves on as a bubble.
      for (int s = 1; s < DEPTH; s++) begin
        slots[s] <= (s == 1 && ex_flush) ? '0 : slots[s-1];
      end
      ex_fwd_sel <= insert ? ex_sel_next : '0;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a DEPTH=3 instance for the main behaviour
// and a DEPTH=4 instance with a 2-bit counter for long latencies and saturation.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DEPTH=3 instance ----------------
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_use;
  logic [1:0]  id_src_early;
  logic        id_we;
  logic [4:0]  id_dst;
  logic [1:0]  id_lat;
  logic        ex_flush;
  logic        stall;
  logic [3:0]  id_fwd_sel;
  logic [3:0]  ex_fwd_sel;
  logic [31:0] stall_cnt;

  fwd_scoreboard #(.NUM_SRC(2), .AW(5), .DEPTH(3), .LW(2), .CW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_use   (id_src_use),
    .id_src_early (id_src_early),
    .id_we        (id_we),
    .id_dst       (id_dst),
    .id_lat       (id_lat),
    .ex_flush     (ex_flush),
    .stall        (stall),
    .id_fwd_sel   (id_fwd_sel),
    .ex_fwd_sel   (ex_fwd_sel),
    .stall_cnt    (stall_cnt)
  );

  // ---------------- DEPTH=4 instance ----------------
  logic        d4_valid;
  logic [9:0]  d4_src;
  logic [1:0]  d4_use;
  logic [1:0]  d4_early;
  logic        d4_we;
  logic [4:0]  d4_dst;
  logic [2:0]  d4_lat;
  logic        d4_flush;
  logic        d4_stall;
  logic [5:0]  d4_id_sel;
  logic [5:0]  d4_ex_sel;
  logic [1:0]  d4_cnt;

  fwd_scoreboard #(.NUM_SRC(2), .AW(5), .DEPTH(4), .LW(3), .CW(2)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (d4_valid),
    .id_src       (d4_src),
    .id_src_use   (d4_use),
    .id_src_early (d4_early),
    .id_we        (d4_we),
    .id_dst       (d4_dst),
    .id_lat       (d4_lat),
    .ex_flush     (d4_flush),
    .stall        (d4_stall),
    .id_fwd_sel   (d4_id_sel),
    .ex_fwd_sel   (d4_ex_sel),
    .stall_cnt    (d4_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic ins(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] use_v,
                     input logic [1:0] early_v, input logic we, input logic [4:0] dst,
                     input logic [1:0] lat);
    id_valid     = 1'b1;
    id_src       = {s1, s0};
    id_src_use   = use_v;
    id_src_early = early_v;
    id_we        = we;
    id_dst       = dst;
    id_lat       = lat;
    ex_flush     = 1'b0;
  endtask

  task automatic bub();
    id_valid = 1'b0; id_src = '0; id_src_use = '0; id_src_early = '0;
    id_we = 1'b0; id_dst = '0; id_lat = '0; ex_flush = 1'b0;
  endtask

  task automatic ins4(input logic [4:0] s0, input logic use0, input logic we,
                      input logic [4:0] dst, input logic [2:0] lat);
    d4_valid = 1'b1; d4_src = {5'd0, s0}; d4_use = {1'b0, use0}; d4_early = '0;
    d4_we = we; d4_dst = dst; d4_lat = lat; d4_flush = 1'b0;
  endtask

  task automatic bub4();
    d4_valid = 1'b0; d4_src = '0; d4_use = '0; d4_early = '0;
    d4_we = 1'b0; d4_dst = '0; d4_lat = '0; d4_flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bub();
    bub4();
    repeat (4) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bub();
    bub4();
    #3;
    check("rst_stall", 32'(stall), 0);
    check("rst_id_sel", 32'(id_fwd_sel), 0);
    check("rst_ex_sel", 32'(ex_fwd_sel), 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_d4_cnt", 32'(d4_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ALU producer directly ahead
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd8, 2'd1); tick();
    ins(5'd8, 5'd0, 2'b01, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("alu_adj_stall", 32'(stall), 0);
    tick();
    check("alu_adj_ex", 32'(ex_fwd_sel), 1);

    // one independent instruction between
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd8, 2'd1); tick();
    ins(5'd1, 5'd2, 2'b11, 2'b00, 1'b1, 5'd10, 2'd1); tick();
    ins(5'd8, 5'd0, 2'b01, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("alu_gap1_stall", 32'(stall), 0);
    tick();
    check("alu_gap1_ex", 32'(ex_fwd_sel), 2);

    // two between: producer retires, register file covers it
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd8, 2'd1); tick();
    ins(5'd1, 5'd2, 2'b11, 2'b00, 1'b1, 5'd10, 2'd1); tick();
    ins(5'd1, 5'd2, 2'b11, 2'b00, 1'b1, 5'd11, 2'd1); tick();
    ins(5'd8, 5'd0, 2'b01, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("alu_gap2_stall", 32'(stall), 0);
    tick();
    check("alu_gap2_ex", 32'(ex_fwd_sel), 0);

    // load-use on operand 1
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd9, 2'(LAT_LOAD)); tick();
    ins(5'd0, 5'd9, 2'b10, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("load_stall_on", 32'(stall), 1);
    check("load_cnt_pre", stall_cnt, 0);
    tick();
    check("load_bubble_ex", 32'(ex_fwd_sel), 0);
    check("load_cnt", stall_cnt, 1);
    check("load_stall_off", 32'(stall), 0);
    tick();
    check("load_ex_op1", 32'(ex_fwd_sel), 32'(FWD_WB << 2));

    // writer of $0
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd0, 2'd2); tick();
    ins(5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("zero_stall", 32'(stall), 0);
    tick();
    check("zero_ex", 32'(ex_fwd_sel), 0);

    // two writers of $5: younger wins
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd5, 2'd1); tick();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd5, 2'd1); tick();
    ins(5'd5, 5'd0, 2'b01, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("young_stall", 32'(stall), 0);
    tick();
    check("young_ex", 32'(ex_fwd_sel), 32'(FWD_MEM));

    // early branch compare behind an ALU writer
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd3, 2'd1); tick();
    ins(5'd3, 5'd0, 2'b01, 2'b01, 1'b0, 5'd0, 2'd1); #1;
    check("br_stall_on", 32'(stall), 1);
    check("br_id_sel_wait", 32'(id_fwd_sel), 0);
    tick();
    check("br_stall_off", 32'(stall), 0);
    check("br_id_sel", 32'(id_fwd_sel), 1);
    check("br_cnt", stall_cnt, 2);
    tick();
    check("br_ex", 32'(ex_fwd_sel), 2);

    // flush in the load-hazard cycle
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd9, 2'd2); tick();
    ins(5'd0, 5'd9, 2'b10, 2'b00, 1'b0, 5'd0, 2'd1);
    ex_flush = 1'b1; #1;
    check("flush_stall", 32'(stall), 0);
    tick();
    check("flush_ex", 32'(ex_fwd_sel), 0);
    check("flush_cnt", stall_cnt, 2);
    ex_flush = 1'b0; #1;
    check("flush_squashed_stall", 32'(stall), 0);
    tick();
    check("flush_squashed_ex", 32'(ex_fwd_sel), 0);

    // reset pulsed mid-stall
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd9, 2'd2); tick();
    ins(5'd0, 5'd9, 2'b10, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("rst_mid_stall_pre", 32'(stall), 1);
    reset = 1'b0; #1;
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_cnt", stall_cnt, 0);
    check("rst_mid_ex", 32'(ex_fwd_sel), 0);
    check("rst_mid_id_sel", 32'(id_fwd_sel), 0);
    reset = 1'b1; #1;
    check("rst_rel_stall", 32'(stall), 0);
    tick();
    check("rst_rel_ex", 32'(ex_fwd_sel), 0);

    // latency 0 behaves as 1
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd8, 2'd0); tick();
    ins(5'd8, 5'd0, 2'b01, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("lat0_stall", 32'(stall), 0);
    tick();
    check("lat0_ex", 32'(ex_fwd_sel), 1);

    // latency 3 at DEPTH 3: two stalls then register file
    drain();
    ins(5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 5'd7, 2'd3); tick();
    ins(5'd7, 5'd0, 2'b01, 2'b00, 1'b0, 5'd0, 2'd1); #1;
    check("lat3_stall_1", 32'(stall), 1);
    tick();
    check("lat3_stall_2", 32'(stall), 1);
    tick();
    check("lat3_stall_3", 32'(stall), 0);
    check("lat3_cnt", stall_cnt, 2);
    tick();
    check("lat3_ex", 32'(ex_fwd_sel), 0);

    // DEPTH 4: lat-3 multiply
    drain();
    ins4(5'd0, 1'b0, 1'b1, 5'd12, 3'd3); tick();
    ins4(5'd12, 1'b1, 1'b0, 5'd0, 3'd1); #1;
    check("mul_stall_1", 32'(d4_stall), 1);
    tick();
    check("mul_stall_2", 32'(d4_stall), 1);
    tick();
    check("mul_stall_3", 32'(d4_stall), 0);
    check("mul_cnt", 32'(d4_cnt), 2);
    tick();
    check("mul_ex", 32'(d4_ex_sel), 3);

    // DEPTH 4: latency 7 clamps to 4, counter saturates
    drain();
    ins4(5'd0, 1'b0, 1'b1, 5'd13, 3'd7); tick();
    ins4(5'd13, 1'b1, 1'b0, 5'd0, 3'd1); #1;
    check("clamp_stall_1", 32'(d4_stall), 1);
    tick();
    check("clamp_stall_2", 32'(d4_stall), 1);
    tick();
    check("clamp_stall_3", 32'(d4_stall), 1);
    tick();
    check("clamp_stall_4", 32'(d4_stall), 0);
    check("sat_cnt", 32'(d4_cnt), 3);
    tick();
    check("clamp_ex", 32'(d4_ex_sel), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
